// File: rtl/fabric_rst_pkg.sv
// Shared types for the fabric reset sequencer: state encoding seen on STATE_DBG
// and the saturating lock-loss counter helper.
package fabric_rst_pkg;

  typedef enum logic [2:0] {
    ST_PD        = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_RUN       = 3'd4,
    ST_SOFT      = 3'd5
  } rst_state_e;

  localparam int unsigned LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = 8'd255;

  function automatic logic [LOSS_CNT_W-1:0] loss_inc(input logic [LOSS_CNT_W-1:0] cnt);
    return (cnt == LOSS_CNT_MAX) ? cnt : cnt + 8'd1;
  endfunction

endpackage

// File: rtl/fabric_reset_sequencer_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; cleared by RST.
module sync_2ff (
  input  logic CLK,
  input  logic RST,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/fabric_reset_sequencer.sv
// Brings up the fabric PLL, qualifies lock, then releases the FIC domain resets
// one at a time; handles lock loss and masked soft-reset requests.
module fabric_reset_sequencer
  import fabric_rst_pkg::*;
#(
  parameter int unsigned N_DOMAINS       = 4,
  parameter int unsigned PD_CYC          = 8,
  parameter int unsigned LOCK_STABLE_CYC = 256,
  parameter int unsigned STAGE_DLY_CYC   = 16,
  parameter int unsigned CNT_W           = 9
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  PLL_LOCK,
  input  logic                  INIT_DONE,
  input  logic                  SOFT_RST_REQ,
  input  logic [N_DOMAINS-1:0]  SOFT_RST_MASK,
  output logic                  PLL_POWERDOWN_N,
  output logic [N_DOMAINS-1:0]  RESETN_OUT,
  output logic                  READY,
  output logic                  SOFT_RST_ACK,
  output logic [LOSS_CNT_W-1:0] LOCK_LOSS_CNT,
  output logic [2:0]            STATE_DBG
);

  localparam int unsigned IDX_W = (N_DOMAINS > 1) ? $clog2(N_DOMAINS) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(N_DOMAINS - 1);
  localparam logic [CNT_W-1:0] PD_LAST     = CNT_W'(PD_CYC - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST  = CNT_W'(STAGE_DLY_CYC - 1);

  logic [1:0] async_in;
  logic [1:0] sync_out;
  logic       lock_s;
  logic       init_s;

  assign async_in = {INIT_DONE, PLL_LOCK};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_sync
      sync_2ff u_sync (
        .CLK     (CLK),
        .RST     (RST),
        .async_i (async_in[gi]),
        .sync_o  (sync_out[gi])
      );
    end
  endgenerate

  assign lock_s = sync_out[0];
  assign init_s = sync_out[1];

  rst_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  pd_n_q, pd_n_d;
  logic [N_DOMAINS-1:0]  resetn_q, resetn_d;
  logic                  ready_q, ready_d;
  logic                  ack_q, ack_d;
  logic [LOSS_CNT_W-1:0] loss_q, loss_d;
  logic                  domains_live;

  // Once any domain may be out of reset, a lock drop must pull everything back.
  assign domains_live = (state_q == ST_RELEASE) || (state_q == ST_RUN) || (state_q == ST_SOFT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    pd_n_d   = pd_n_q;
    resetn_d = resetn_q;
    ready_d  = ready_q;
    ack_d    = ack_q;
    loss_d   = loss_q;

    if (domains_live && !lock_s) begin
      state_d  = ST_WAIT_LOCK;
      cnt_d    = '0;
      resetn_d = '0;
      ready_d  = 1'b0;
      ack_d    = 1'b0;
      loss_d   = loss_inc(loss_q);
    end else begin
      case (state_q)
        ST_PD: begin
          pd_n_d = 1'b0;
          if (cnt_q == PD_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            pd_n_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_WAIT_LOCK: begin
          pd_n_d = 1'b1;
          if (lock_s && init_s) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end
        end
        ST_STABLE: begin
          if (!lock_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            loss_d  = loss_inc(loss_q);
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RELEASE;
            cnt_d   = '0;
            idx_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAGE_LAST) begin
            cnt_d           = '0;
            resetn_d[idx_q] = 1'b1;
            idx_d           = idx_q + IDX_W'(1);
            if (idx_q == IDX_LAST) begin
              state_d = ST_RUN;
              ready_d = 1'b1;
              idx_d   = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ST_RUN: begin
          ready_d = 1'b1;
          if (SOFT_RST_REQ) begin
            state_d  = ST_SOFT;
            cnt_d    = '0;
            resetn_d = resetn_q & ~SOFT_RST_MASK;
            ready_d  = 1'b0;
          end
        end
        ST_SOFT: begin
          // The counter parks at its terminal value while ACK is held.
          if (!ack_q) begin
            if (cnt_q == STAGE_LAST) begin
              ack_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end else if (!SOFT_RST_REQ) begin
            state_d  = ST_RUN;
            cnt_d    = '0;
            resetn_d = '1;
            ack_d    = 1'b0;
            ready_d  = 1'b1;
          end
        end
        default: begin
          state_d  = ST_WAIT_LOCK;
          cnt_d    = '0;
          resetn_d = '0;
          ready_d  = 1'b0;
          ack_d    = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= ST_PD;
      cnt_q    <= '0;
      idx_q    <= '0;
      pd_n_q   <= 1'b0;
      resetn_q <= '0;
      ready_q  <= 1'b0;
      ack_q    <= 1'b0;
      loss_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pd_n_q   <= pd_n_d;
      resetn_q <= resetn_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      loss_q   <= loss_d;
    end
  end

  assign PLL_POWERDOWN_N = pd_n_q;
  assign RESETN_OUT      = resetn_q;
  assign READY           = ready_q;
  assign SOFT_RST_ACK    = ack_q;
  assign LOCK_LOSS_CNT   = loss_q;
  assign STATE_DBG       = state_q;

endmodule

// File: tb/tb_fabric_reset_sequencer.sv
// Directed bench for fabric_reset_sequencer: a vector table walks bring-up, soft
// reset, lock loss and mid-sequence RST; hand sequences cover counter saturation.
module tb_fabric_reset_sequencer;
  import fabric_rst_pkg::*;

  localparam int N = 4;

  logic         CLK = 1'b0;
  logic         RST;
  logic         PLL_LOCK;
  logic         INIT_DONE;
  logic         SOFT_RST_REQ;
  logic [N-1:0] SOFT_RST_MASK;
  logic         PLL_POWERDOWN_N;
  logic [N-1:0] RESETN_OUT;
  logic         READY;
  logic         SOFT_RST_ACK;
  logic [7:0]   LOCK_LOSS_CNT;
  logic [2:0]   STATE_DBG;

  fabric_reset_sequencer #(
    .N_DOMAINS       (N),
    .PD_CYC          (8),
    .LOCK_STABLE_CYC (16),
    .STAGE_DLY_CYC   (4),
    .CNT_W           (9)
  ) dut (
    .CLK             (CLK),
    .RST             (RST),
    .PLL_LOCK        (PLL_LOCK),
    .INIT_DONE       (INIT_DONE),
    .SOFT_RST_REQ    (SOFT_RST_REQ),
    .SOFT_RST_MASK   (SOFT_RST_MASK),
    .PLL_POWERDOWN_N (PLL_POWERDOWN_N),
    .RESETN_OUT      (RESETN_OUT),
    .READY           (READY),
    .SOFT_RST_ACK    (SOFT_RST_ACK),
    .LOCK_LOSS_CNT   (LOCK_LOSS_CNT),
    .STATE_DBG       (STATE_DBG)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       rst, lock, init, req;
    logic [3:0] mask;
    int         adv;
    logic       pd_n;
    logic [3:0] resetn;
    logic       ready, ack;
    logic [7:0] loss;
    logic [2:0] st;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(logic rst, logic lock, logic init, logic req, logic [3:0] mask,
                              int adv, logic pd_n, logic [3:0] resetn, logic ready,
                              logic ack, logic [7:0] loss, logic [2:0] st);
    vec_t v;
    v.rst = rst; v.lock = lock; v.init = init; v.req = req; v.mask = mask; v.adv = adv;
    v.pd_n = pd_n; v.resetn = resetn; v.ready = ready; v.ack = ack; v.loss = loss; v.st = st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic pd_n, input logic [3:0] resetn,
                         input logic ready, input logic ack, input logic [7:0] loss,
                         input logic [2:0] st);
    chk({tag, ".pd_n"},   PLL_POWERDOWN_N, pd_n);
    chk({tag, ".resetn"}, RESETN_OUT,      resetn);
    chk({tag, ".ready"},  READY,           ready);
    chk({tag, ".ack"},    SOFT_RST_ACK,    ack);
    chk({tag, ".loss"},   LOCK_LOSS_CNT,   loss);
    chk({tag, ".state"},  STATE_DBG,       st);
    $display("%s: state=%0d pd_n=%b resetn=%b ready=%b ack=%b loss=%0d",
             tag, STATE_DBG, PLL_POWERDOWN_N, RESETN_OUT, READY, SOFT_RST_ACK, LOCK_LOSS_CNT);
  endtask

  initial begin
    RST = 1'b1; PLL_LOCK = 1'b1; INIT_DONE = 1'b1; SOFT_RST_REQ = 1'b0; SOFT_RST_MASK = '0;

    //                rst lk in rq mask    adv pdn resetn  rdy ack loss st
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000,  2, 0, 4'b0000, 0, 0, 0, ST_PD));
    // bring-up with lock and init held
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  7, 0, 4'b0000, 0, 0, 0, ST_PD));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 0, ST_WAIT_LOCK));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 0, ST_STABLE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 16, 1, 4'b0000, 0, 0, 0, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  3, 1, 4'b0000, 0, 0, 0, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0001, 0, 0, 0, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  4, 1, 4'b0011, 0, 0, 0, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  4, 1, 4'b0111, 0, 0, 0, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  3, 1, 4'b0111, 0, 0, 0, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b1111, 1, 0, 0, ST_RUN));
    // soft reset on domains 0 and 2; mask changes after acceptance are ignored
    vecs.push_back(mk(0, 1, 1, 1, 4'b0101,  1, 1, 4'b1010, 0, 0, 0, ST_SOFT));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1111,  3, 1, 4'b1010, 0, 0, 0, ST_SOFT));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1111,  1, 1, 4'b1010, 0, 1, 0, ST_SOFT));
    vecs.push_back(mk(0, 1, 1, 1, 4'b1111,  3, 1, 4'b1010, 0, 1, 0, ST_SOFT));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b1111, 1, 0, 0, ST_RUN));
    // empty mask still runs the full handshake
    vecs.push_back(mk(0, 1, 1, 1, 4'b0000,  1, 1, 4'b1111, 0, 0, 0, ST_SOFT));
    vecs.push_back(mk(0, 1, 1, 1, 4'b0000,  4, 1, 4'b1111, 0, 1, 0, ST_SOFT));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b1111, 1, 0, 0, ST_RUN));
    // lock drop in RUN; soft request arrives on the same edge lock_s falls
    vecs.push_back(mk(0, 0, 1, 0, 4'b0000,  2, 1, 4'b1111, 1, 0, 0, ST_RUN));
    vecs.push_back(mk(0, 0, 1, 1, 4'b1111,  1, 1, 4'b0000, 0, 0, 1, ST_WAIT_LOCK));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  2, 1, 4'b0000, 0, 0, 1, ST_WAIT_LOCK));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 1, ST_STABLE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 16, 1, 4'b0000, 0, 0, 1, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  3, 1, 4'b0000, 0, 0, 1, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0001, 0, 0, 1, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 12, 1, 4'b1111, 1, 0, 1, ST_RUN));
    // fresh reset, then a 3-cycle lock drop midway through STABLE
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000,  1, 0, 4'b0000, 0, 0, 0, ST_PD));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  8, 1, 4'b0000, 0, 0, 0, ST_WAIT_LOCK));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 0, ST_STABLE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  8, 1, 4'b0000, 0, 0, 0, ST_STABLE));
    vecs.push_back(mk(0, 0, 1, 0, 4'b0000,  2, 1, 4'b0000, 0, 0, 0, ST_STABLE));
    vecs.push_back(mk(0, 0, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 1, ST_WAIT_LOCK));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  2, 1, 4'b0000, 0, 0, 1, ST_WAIT_LOCK));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 1, ST_STABLE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000, 15, 1, 4'b0000, 0, 0, 1, ST_STABLE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 1, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  4, 1, 4'b0001, 0, 0, 1, ST_RELEASE));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  4, 1, 4'b0011, 0, 0, 1, ST_RELEASE));
    // RST in the middle of RELEASE restarts from PD
    vecs.push_back(mk(1, 1, 1, 0, 4'b0000,  1, 0, 4'b0000, 0, 0, 0, ST_PD));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  7, 0, 4'b0000, 0, 0, 0, ST_PD));
    vecs.push_back(mk(0, 1, 1, 0, 4'b0000,  1, 1, 4'b0000, 0, 0, 0, ST_WAIT_LOCK));

    for (int i = 0; i < vecs.size(); i++) begin
      RST           = vecs[i].rst;
      PLL_LOCK      = vecs[i].lock;
      INIT_DONE     = vecs[i].init;
      SOFT_RST_REQ  = vecs[i].req;
      SOFT_RST_MASK = vecs[i].mask;
      step(vecs[i].adv);
      chk_all($sformatf("vec%0d", i), vecs[i].pd_n, vecs[i].resetn, vecs[i].ready,
              vecs[i].ack, vecs[i].loss, vecs[i].st);
    end

    // 300 short lock pulses, each giving exactly one drop out of STABLE
    for (int k = 0; k < 300; k++) begin
      PLL_LOCK = 1'b1;
      step(3);
      PLL_LOCK = 1'b0;
      step(3);
      if (k == 99) chk_all("drops100", 1, 4'b0000, 0, 0, 8'd100, ST_WAIT_LOCK);
    end
    chk_all("drops300", 1, 4'b0000, 0, 0, 8'd255, ST_WAIT_LOCK);

    // soft request while stuck in WAIT_LOCK is ignored and not remembered
    INIT_DONE = 1'b0;
    step(3);
    PLL_LOCK = 1'b1; SOFT_RST_REQ = 1'b1; SOFT_RST_MASK = 4'b1111;
    step(10);
    chk_all("req_wait", 1, 4'b0000, 0, 0, 8'd255, ST_WAIT_LOCK);
    SOFT_RST_REQ = 1'b0; INIT_DONE = 1'b1;
    step(34);
    chk_all("relock_rel", 1, 4'b0111, 0, 0, 8'd255, ST_RELEASE);
    step(1);
    chk_all("relock_run", 1, 4'b1111, 1, 0, 8'd255, ST_RUN);
    step(2);
    chk_all("run_hold", 1, 4'b1111, 1, 0, 8'd255, ST_RUN);

    // drop with the loss counter already saturated
    PLL_LOCK = 1'b0;
    step(3);
    chk_all("sat_drop", 1, 4'b0000, 0, 0, 8'd255, ST_WAIT_LOCK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
